seg7_scan_capture: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display interface. It samples the time-multiplexed `HEX_TO_CELL`/`SEGMENT_SELECT` bus and decodes each digit's segment pattern back to a hex nibble and a dot flag. It assembles full four-digit frames and publishes a frame only after it has been captured identically several times in a row. It sits in loopback/self-test builds next to the counter/display path, or on boards that read an external multiplexed display.

---
 rtl/seg7_pkg.sv | 70 +++++++
 rtl/seg7_pattern_decoder.sv | 38 +++
 rtl/seg7_scan_capture.sv | 241 ++++++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed seven-segment capture path.
//   - active-low segment pattern constants for hex digits 0..F (bit0=a .. bit6=g)
//   - capture FSM state encoding
//   - select helpers (validity, select-to-index) and the nibble->pattern encoder,
//     the inverse of seg7_pattern_decoder, shared with the display side
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } seg7_state_t;

    // Exactly one anode low selects a digit; blank and multi-low are rejected.
    function automatic logic sel_is_valid(input logic [3:0] sel);
        case (sel)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sel_to_idx(input logic [3:0] sel);
        case (sel)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: combinational active-low 7-segment pattern -> hex nibble.
// Ports:
//   i_pattern [6:0] : segments a..g, active-low
//   o_nibble  [3:0] : decoded value, 0 when the pattern is not a hex glyph
//   o_invalid       : pattern is not one of the 16 hex glyphs
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_invalid
);

    always_comb begin
        o_nibble  = 4'h0;
        o_invalid = 1'b0;
        case (i_pattern)
            SEG_0: o_nibble = 4'h0;
            SEG_1: o_nibble = 4'h1;
            SEG_2: o_nibble = 4'h2;
            SEG_3: o_nibble = 4'h3;
            SEG_4: o_nibble = 4'h4;
            SEG_5: o_nibble = 4'h5;
            SEG_6: o_nibble = 4'h6;
            SEG_7: o_nibble = 4'h7;
            SEG_8: o_nibble = 4'h8;
            SEG_9: o_nibble = 4'h9;
            SEG_A: o_nibble = 4'hA;
            SEG_B: o_nibble = 4'hB;
            SEG_C: o_nibble = 4'hC;
            SEG_D: o_nibble = 4'hD;
            SEG_E: o_nibble = 4'hE;
            SEG_F: o_nibble = 4'hF;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a time-multiplexed seven-segment bus, decodes each
// digit back to a nibble + dot flag, assembles four-digit frames and publishes a
// frame once it has been captured identically STABLE_FRAMES times in a row.
// Optional feature macro: SEG7_CAPTURE_ERR_EN (invalid patterns flag DECODE_ERROR
// and disqualify the frame they land in).
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   HEX_TO_CELL [7:0]   : segments a..g + DP (bit7), active-low
//   SEGMENT_SELECT [3:0]: digit anodes, active-low, digit 0 rightmost
//   DIGITS [15:0]       : published nibbles {d3,d2,d1,d0}
//   DOTS [3:0]          : published dot flags, 1 = lit
//   FRAME_VALID         : one-cycle pulse when DIGITS/DOTS update
//   LOCKED              : published data is current
//   DECODE_ERROR        : sticky invalid-pattern flag (0 without the macro)
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  HEX_TO_CELL,
    input  logic [3:0]  SEGMENT_SELECT,
    output logic [15:0] DIGITS,
    output logic [3:0]  DOTS,
    output logic        FRAME_VALID,
    output logic        LOCKED,
    output logic        DECODE_ERROR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    seg7_state_t r_state, w_next_state;

    logic [3:0]       r_sel;
    logic [7:0]       r_settle_cnt;
    logic [7:0]       r_seg;
    logic [TW-1:0]    r_idle_cnt;
    logic [3:0][3:0]  r_dig;
    logic [3:0]       r_dot;
    logic [3:0]       r_seen;
    logic [19:0]      r_prev_frame;
    logic [3:0]       r_match;
    logic [15:0]      r_digits;
    logic [3:0]       r_dots;
    logic             r_frame_valid;
    logic             r_locked;

    logic             w_sel_valid;
    logic             w_sel_change;
    logic             w_restart;
    logic             w_cnt_inc;
    logic             w_sample;
    logic             w_capture;
    logic             w_timeout;
    logic [1:0]       w_idx;
    logic [3:0]       w_nib;
    logic             w_invalid;
    logic [3:0][3:0]  w_frame_dig;
    logic [3:0]       w_frame_dot;
    logic [3:0]       w_seen_nx;
    logic [19:0]      w_frame;
    logic             w_close;
    logic [3:0]       w_match_nx;
    logic             w_publish;
    logic             w_frame_bad;

    assign w_sel_valid  = sel_is_valid(SEGMENT_SELECT);
    assign w_sel_change = (SEGMENT_SELECT != r_sel);
    assign w_idx        = sel_to_idx(r_sel);

    seg7_pattern_decoder u_dec (
        .i_pattern (r_seg[6:0]),
        .o_nibble  (w_nib),
        .o_invalid (w_invalid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // A select change in any state restarts the settle on the new value in the
    // same cycle, so a fresh digit is never delayed by an extra IDLE cycle.
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_sample     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_restart    = 1'b1;
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_sel_change) begin
                    w_restart    = 1'b1;
                    w_next_state = w_sel_valid ? ST_SETTLE : ST_IDLE;
                end else if (r_settle_cnt + 8'd1 == 8'(SETTLE_CYCLES)) begin
                    w_sample     = 1'b1;
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                if (w_sel_change) begin
                    w_restart    = 1'b1;
                    w_next_state = w_sel_valid ? ST_SETTLE : ST_IDLE;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_sel_change) begin
                    w_restart    = 1'b1;
                    w_next_state = w_sel_valid ? ST_SETTLE : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

`ifdef SEG7_CAPTURE_ERR_EN
    logic r_err_pend;
    logic r_decode_error;

    assign w_frame_bad = r_err_pend | w_invalid;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_err_pend     <= 1'b0;
            r_decode_error <= 1'b0;
        end else if (w_capture) begin
            if (w_invalid) r_decode_error <= 1'b1;
            // The pending flag lives for one frame only.
            r_err_pend <= w_close ? 1'b0 : w_frame_bad;
        end else if (w_timeout) begin
            r_err_pend <= 1'b0;
        end
    end

    assign DECODE_ERROR = r_decode_error;
`else
    logic w_unused_invalid;
    assign w_unused_invalid = w_invalid;
    assign w_frame_bad      = 1'b0;
    assign DECODE_ERROR     = 1'b0;
`endif

    // Frame as it will look once the digit in CAPTURE is written.
    always_comb begin
        w_frame_dig        = r_dig;
        w_frame_dot        = r_dot;
        w_frame_dig[w_idx] = w_nib;
        w_frame_dot[w_idx] = ~r_seg[7];
        w_seen_nx          = r_seen | (4'b0001 << w_idx);
        w_frame            = {w_frame_dot, w_frame_dig};
        w_close            = w_capture & (&w_seen_nx);
        if (w_frame != r_prev_frame)
            w_match_nx = 4'd1;
        else if (r_match == 4'hF)
            w_match_nx = 4'hF;
        else
            w_match_nx = r_match + 4'd1;
        if (w_frame_bad)
            w_match_nx = 4'd0;
        w_publish = w_close && (w_match_nx >= 4'(STABLE_FRAMES)) &&
                    ((w_frame != {r_dots, r_digits}) || !r_locked);
    end

    // Capture wins over a timeout landing on the same edge.
    assign w_timeout = !w_capture && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sel         <= 4'hF;
            r_settle_cnt  <= 8'd0;
            r_seg         <= 8'hFF;
            r_idle_cnt    <= '0;
            r_dig         <= '0;
            r_dot         <= 4'd0;
            r_seen        <= 4'd0;
            r_prev_frame  <= 20'd0;
            r_match       <= 4'd0;
            r_digits      <= 16'd0;
            r_dots        <= 4'd0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;

            if (w_restart) begin
                r_sel        <= SEGMENT_SELECT;
                r_settle_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end

            if (w_sample) r_seg <= HEX_TO_CELL;

            if (w_capture) begin
                r_idle_cnt <= '0;
                r_dig      <= w_frame_dig;
                r_dot      <= w_frame_dot;
                if (w_close) begin
                    r_seen       <= 4'd0;
                    r_prev_frame <= w_frame;
                    r_match      <= w_match_nx;
                end else begin
                    r_seen <= w_seen_nx;
                end
                if (w_publish) begin
                    r_digits      <= w_frame[15:0];
                    r_dots        <= w_frame[19:16];
                    r_frame_valid <= 1'b1;
                    r_locked      <= 1'b1;
                end
            end else if (w_timeout) begin
                r_idle_cnt <= '0;
                r_locked   <= 1'b0;
                r_seen     <= 4'd0;
                r_match    <= 4'd0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign DIGITS      = r_digits;
    assign DOTS        = r_dots;
    assign FRAME_VALID = r_frame_valid;
    assign LOCKED      = r_locked;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: drives scanned frames, a frame-level reference
// model pushes each expected publish into a queue, and a monitor pops and
// compares whenever FRAME_VALID pulses.
module tb_seg7_scan_capture;

    localparam int SETTLE  = 4;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 200;
`ifdef SEG7_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  HEX_TO_CELL;
    logic [3:0]  SEGMENT_SELECT;
    logic [15:0] DIGITS;
    logic [3:0]  DOTS;
    logic        FRAME_VALID;
    logic        LOCKED;
    logic        DECODE_ERROR;

    seg7_scan_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .STABLE_FRAMES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .HEX_TO_CELL    (HEX_TO_CELL),
        .SEGMENT_SELECT (SEGMENT_SELECT),
        .DIGITS         (DIGITS),
        .DOTS           (DOTS),
        .FRAME_VALID    (FRAME_VALID),
        .LOCKED         (LOCKED),
        .DECODE_ERROR   (DECODE_ERROR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // frame-level reference state
    logic [19:0] exp_q[$];
    logic [19:0] m_prev;
    logic [19:0] m_pub;
    int          m_match;
    bit          m_locked;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        m_prev   = '0;
        m_pub    = '0;
        m_match  = 0;
        m_locked = 0;
    endtask

    task automatic model_close(input logic [19:0] frame, input bit bad);
        if (frame != m_prev) m_match = 1;
        else if (m_match < 15) m_match++;
        if (bad) m_match = 0;
        m_prev = frame;
        if (m_match >= STABLE && (frame != m_pub || !m_locked)) begin
            exp_q.push_back(frame);
            m_pub    = frame;
            m_locked = 1;
        end
    endtask

    // Scans digits 0..3; digits flagged in bad get the blank pattern 8'hFF.
    // The expectation is registered before driving, since the publish lands
    // inside the last dwell.
    task automatic scan_frame(input logic [15:0] digs, input logic [3:0] dots,
                              input int dwell, input logic [3:0] bad);
        logic [15:0] fdig;
        logic [3:0]  nib;
        fdig = digs;
        for (int d = 0; d < 4; d++)
            if (bad[d]) fdig[d*4 +: 4] = 4'h0;
        if (dwell >= SETTLE + 1)
            model_close({dots & ~bad, fdig}, ERR_EN && (bad != 4'b0000));
        for (int d = 0; d < 4; d++) begin
            nib = digs[d*4 +: 4];
            @(negedge CLK);
            SEGMENT_SELECT = ~(4'b0001 << d);
            HEX_TO_CELL    = bad[d] ? 8'hFF : {~dots[d], pat(nib)};
            repeat (dwell - 1) @(negedge CLK);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_digits"}, 32'(DIGITS), 32'h0);
        chk({pfx, "_dots"},   32'(DOTS), 32'h0);
        chk({pfx, "_fv"},     32'(FRAME_VALID), 32'h0);
        chk({pfx, "_locked"}, 32'(LOCKED), 32'h0);
        chk({pfx, "_decerr"}, 32'(DECODE_ERROR), 32'h0);
    endtask

    // Monitor: every FRAME_VALID cycle must match the head of the queue.
    always @(negedge CLK) begin
        if (!RESET && FRAME_VALID) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", 32'(FRAME_VALID), 32'h0);
            else chk("publish", 32'({DOTS, DIGITS}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        RESET          = 1'b1;
        HEX_TO_CELL    = 8'hFF;
        SEGMENT_SELECT = 4'hF;
        model_reset();
        repeat (3) @(negedge CLK);
        check_reset_vals("rst");
        RESET = 1'b0;

        // "12.34": DP only on digit 2
        for (int i = 0; i < 3; i++) scan_frame(16'h1234, 4'b0100, 10, 4'b0000);
        chk("lock_digits", 32'(DIGITS), 32'h1234);
        chk("lock_dots",   32'(DOTS), 32'b0100);
        chk("lock_locked", 32'(LOCKED), 32'h1);
        chk("lock_q_empty", 32'(exp_q.size()), 32'h0);

        // blank long enough to time out
        @(negedge CLK);
        SEGMENT_SELECT = 4'hF;
        HEX_TO_CELL    = 8'hFF;
        repeat (TIMEOUT / 2) @(negedge CLK);
        chk("to_still_locked", 32'(LOCKED), 32'h1);
        repeat (TIMEOUT) @(negedge CLK);
        m_locked = 0;
        m_match  = 0;
        chk("to_unlocked", 32'(LOCKED), 32'h0);
        chk("to_digits_kept", 32'(DIGITS), 32'h1234);
        chk("to_dots_kept", 32'(DOTS), 32'b0100);

        // alternating frames never qualify
        for (int i = 0; i < 2; i++) begin
            scan_frame(16'h1235, 4'b0100, 10, 4'b0000);
            scan_frame(16'h1234, 4'b0100, 10, 4'b0000);
        end
        chk("alt_no_lock", 32'(LOCKED), 32'h0);
        chk("alt_digits", 32'(DIGITS), 32'h1234);
        scan_frame(16'h1235, 4'b0100, 10, 4'b0000);
        scan_frame(16'h1235, 4'b0100, 10, 4'b0000);
        chk("alt_pub_digits", 32'(DIGITS), 32'h1235);
        chk("alt_pub_locked", 32'(LOCKED), 32'h1);

        // reset in the middle of a settle, then relock on a new value
        @(negedge CLK);
        SEGMENT_SELECT = 4'b1110;
        HEX_TO_CELL    = {1'b1, pat(4'h4)};
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_vals("mid_rst");
        RESET = 1'b0;
        model_reset();
        scan_frame(16'hABCD, 4'b1001, 7, 4'b0000);
        chk("relock_one_frame", 32'(LOCKED), 32'h0);
        scan_frame(16'hABCD, 4'b1001, 7, 4'b0000);
        chk("relock_digits", 32'(DIGITS), 32'hABCD);
        chk("relock_dots", 32'(DOTS), 32'b1001);
        chk("relock_locked", 32'(LOCKED), 32'h1);

        // invalid pattern on digit 2
        scan_frame(16'hABCD, 4'b1001, 10, 4'b0100);
        scan_frame(16'hABCD, 4'b1001, 10, 4'b0100);
        chk("err_flag", 32'(DECODE_ERROR), 32'(ERR_EN));
        chk("err_digits", 32'(DIGITS), ERR_EN ? 32'hABCD : 32'hA0CD);
        chk("err_dots", 32'(DOTS), 32'b1001);
        scan_frame(16'hABCD, 4'b1001, 10, 4'b0000);
        scan_frame(16'hABCD, 4'b1001, 10, 4'b0000);
        chk("err_recover_digits", 32'(DIGITS), 32'hABCD);
        chk("err_sticky", 32'(DECODE_ERROR), 32'(ERR_EN));

        // dwells too short to settle never capture
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) scan_frame(16'h1234, 4'b0100, SETTLE, 4'b0000);
        chk("short_no_lock", 32'(LOCKED), 32'h0);
        chk("short_digits", 32'(DIGITS), 32'h0);

        repeat (5) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
